// File: rtl/chan_512_fir_pkg.sv
// Shared types and helpers for the chan_512 FIR coefficient loader.
// A register word packs two taps: {tap_even[31:16], tap_odd[15:0]}.
package chan_512_fir_pkg;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned REG_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ARM
  } fir_state_t;

  function automatic logic [COEF_W-1:0] tap_even(input logic [REG_W-1:0] word);
    return word[31:16];
  endfunction

  function automatic logic [COEF_W-1:0] tap_odd(input logic [REG_W-1:0] word);
    return word[15:0];
  endfunction

endpackage

// File: rtl/chan_512_fir_coef_stab.sv
// Per-pair stability filter: a word must hold for STABLE_CYC cycles before it
// can mark the pair dirty against the currently committed word.
module chan_512_fir_coef_stab
  import chan_512_fir_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] word,
  input  logic [REG_W-1:0] committed,
  input  logic             clr_dirty,
  output logic [REG_W-1:0] stable_word,
  output logic             stable,
  output logic             dirty
);

  logic [REG_W-1:0] last_word;
  logic [3:0]       cnt;
  logic             at_limit;

  assign at_limit    = (cnt == 4'(STABLE_CYC));
  assign stable      = at_limit;
  assign stable_word = last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= '0;
      cnt       <= '0;
      dirty     <= 1'b0;
    end else begin
      last_word <= word;
      if (word != last_word) begin
        cnt <= '0;
      end else if (!at_limit) begin
        cnt <= cnt + 4'd1;
      end
      // Snapshot clear wins: the committed value compared here is about to be
      // replaced by the snapshot, so re-evaluation waits one cycle.
      if (clr_dirty) begin
        dirty <= 1'b0;
      end else if (at_limit) begin
        dirty <= (last_word != committed);
      end
    end
  end

endmodule

// File: rtl/chan_512_fir_coef_loader.sv
// Loads stable software coefficient words into the FIR shadow bank and swaps
// banks on frame sync. Optional swap counter enabled by FIR_COEF_CNT_EN.
module chan_512_fir_coef_loader
  import chan_512_fir_pkg::*;
#(
  parameter int unsigned NUM_PAIRS  = 8,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned ADDR_W     = $clog2(2*NUM_PAIRS)
) (
  input  logic                       user_clk,
  input  logic                       user_rst_n,
  input  logic [NUM_PAIRS*REG_W-1:0] reg_data_in,
  input  logic                       sync_in,
  output logic [ADDR_W-1:0]          coef_addr,
  output logic [COEF_W-1:0]          coef_data,
  output logic                       coef_we,
  output logic                       coef_swap,
  output logic                       busy,
  output logic [15:0]                swap_cnt
);

  fir_state_t       state, state_d;
  logic [REG_W-1:0] committed   [NUM_PAIRS];
  logic [REG_W-1:0] snap        [NUM_PAIRS];
  logic [REG_W-1:0] src         [NUM_PAIRS];
  logic [REG_W-1:0] stable_word [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] stable, dirty;
  logic              load;
  logic              we_d, swap_d;
  logic [ADDR_W-1:0] addr_d;
  logic [COEF_W-1:0] data_d, next_tap;

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_stab
    chan_512_fir_coef_stab #(
      .STABLE_CYC(STABLE_CYC)
    ) u_stab (
      .clk        (user_clk),
      .rst_n      (user_rst_n),
      .word       (reg_data_in[k*REG_W +: REG_W]),
      .committed  (committed[k]),
      .clr_dirty  (load),
      .stable_word(stable_word[k]),
      .stable     (stable[k]),
      .dirty      (dirty[k])
    );
  end

  // Unstable pairs keep their committed word so a torn value is never loaded.
  always_comb begin
    for (int unsigned k = 0; k < NUM_PAIRS; k++) begin
      snap[k] = stable[k] ? stable_word[k] : committed[k];
      src[k]  = load ? snap[k] : committed[k];
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    we_d    = 1'b0;
    swap_d  = 1'b0;
    addr_d  = coef_addr;
    case (state)
      IDLE: begin
        if (|dirty) begin
          load    = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (coef_addr == ADDR_W'(2*NUM_PAIRS-1)) begin
          addr_d  = '0;
          state_d = ARM;
        end else begin
          we_d   = 1'b1;
          addr_d = coef_addr + ADDR_W'(1);
        end
      end
      ARM: begin
        if (sync_in) begin
          swap_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    next_tap = '0;
    for (int unsigned k = 0; k < NUM_PAIRS; k++) begin
      if (addr_d == ADDR_W'(2*k)) begin
        next_tap = tap_even(src[k]);
      end else if (addr_d == ADDR_W'(2*k+1)) begin
        next_tap = tap_odd(src[k]);
      end
    end
    data_d = we_d ? next_tap : coef_data;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      coef_addr <= '0;
      coef_data <= '0;
      coef_we   <= 1'b0;
      coef_swap <= 1'b0;
      committed <= '{default: '0};
    end else begin
      coef_addr <= addr_d;
      coef_data <= data_d;
      coef_we   <= we_d;
      coef_swap <= swap_d;
      if (load) begin
        committed <= snap;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef FIR_COEF_CNT_EN
  logic [15:0] swap_cnt_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      swap_cnt_q <= '0;
    end else if (coef_swap) begin
      swap_cnt_q <= swap_cnt_q + 16'd1;
    end
  end

  assign swap_cnt = swap_cnt_q;
`else
  assign swap_cnt = '0;
`endif

endmodule

// File: tb/tb_chan_512_fir_coef_loader.sv
// Self-checking bench for chan_512_fir_coef_loader: randomized register words,
// expected tap passes derived from the held register values.
module tb_chan_512_fir_coef_loader;

  localparam int unsigned NP = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned NT = 2*NP;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NP*32-1:0]  reg_data = '0;
  logic              sync_in = 1'b0;
  logic [3:0]        coef_addr;
  logic [15:0]       coef_data;
  logic              coef_we, coef_swap, busy;
  logic [15:0]       swap_cnt;

  int checks = 0;
  int failures = 0;
  int swaps_seen = 0;
  int exp_swaps = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] regs [NP];
  logic [19:0] wq [$];

  chan_512_fir_coef_loader #(
    .NUM_PAIRS (NP),
    .STABLE_CYC(SC)
  ) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .reg_data_in(reg_data),
    .sync_in    (sync_in),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_we    (coef_we),
    .coef_swap  (coef_swap),
    .busy       (busy),
    .swap_cnt   (swap_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coef_we === 1'b1) wq.push_back({coef_addr, coef_data});
    if (coef_swap === 1'b1) swaps_seen++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_pair(input int k, input logic [31:0] v);
    regs[k] = v;
    reg_data[k*32 +: 32] = v;
  endtask

  // Tap i of a full pass: even address = high half of word i/2, odd = low half.
  function automatic logic [15:0] exp_tap(input int i);
    logic [31:0] w;
    w = regs[i/2];
    return (i % 2 == 0) ? w[31:16] : w[15:0];
  endfunction

  task automatic test_reset();
    for (int k = 0; k < NP; k++) set_pair(k, 32'h0);
    set_pair(0, 32'h7FFF8000);
    #1 rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({coef_we, coef_swap, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {coef_we, coef_swap, busy});
    end
    checks++;
    if ({coef_addr, coef_data, swap_cnt} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {coef_addr, coef_data, swap_cnt});
    end
  endtask

  task automatic test_basic();
    int n;
    wq.delete();
    rst_n = 1'b1;
    n = 0;
    while (coef_we !== 1'b1 && n < 60) begin tick(); n++; end
    // First posedge sampling the word is tick 1; writes begin SC+2 edges later.
    checks++;
    if (n != SC+3) begin
      failures++;
      $display("FAIL latency got=%0d exp=%0d", n, SC+3);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_write got=%b exp=1", busy);
    end
    for (int i = 0; i < 60 && wq.size() < NT; i++) tick();
    repeat (3) tick();
    checks++;
    if (wq.size() != NT) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=%0d", wq.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wq[i] !== {4'(i), exp_tap(i)}) begin
          failures++;
          $display("FAIL basic_tap%0d got=%h exp=%h", i, wq[i], {4'(i), exp_tap(i)});
        end
      end
    end
    checks++;
    if ({busy, coef_we, coef_addr, coef_data} !== {1'b1, 1'b0, 4'h0, exp_tap(NT-1)}) begin
      failures++;
      $display("FAIL arm_hold got=%h exp=%h", {busy, coef_we, coef_addr, coef_data},
               {1'b1, 1'b0, 4'h0, exp_tap(NT-1)});
    end
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checks++;
    if (coef_swap !== 1'b1) begin
      failures++;
      $display("FAIL basic_swap got=%b exp=1", coef_swap);
    end
    exp_swaps++; exp_cnt++;
    tick();
    checks++;
    if ({coef_swap, busy} !== 2'b00) begin
      failures++;
      $display("FAIL basic_swap_end got=%b exp=00", {coef_swap, busy});
    end
  endtask

  task automatic test_toggle();
    logic [31:0] a, b;
    int s0;
    s0 = swaps_seen;
    wq.delete();
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    a = $urandom | 32'h1;
    b = ~a;
    for (int i = 0; i < 10; i++) begin
      set_pair(3, a); tick(); tick();
      set_pair(3, b); tick(); tick();
    end
    checks++;
    if (wq.size() != 0 || swaps_seen != s0) begin
      failures++;
      $display("FAIL toggle_quiet got=%0d/%0d exp=0/0", wq.size(), swaps_seen - s0);
    end
    set_pair(3, 32'h00010002);
    for (int i = 0; i < 60 && wq.size() < NT; i++) tick();
    repeat (10) tick();
    checks++;
    if (wq.size() != NT) begin
      failures++;
      $display("FAIL toggle_count got=%0d exp=%0d", wq.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wq[i] !== {4'(i), exp_tap(i)}) begin
          failures++;
          $display("FAIL toggle_tap%0d got=%h exp=%h", i, wq[i], {4'(i), exp_tap(i)});
        end
      end
    end
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checks++;
    if (coef_swap !== 1'b1) begin
      failures++;
      $display("FAIL toggle_swap got=%b exp=1", coef_swap);
    end
    exp_swaps++; exp_cnt++;
    tick();
  endtask

  task automatic test_sync_during_write();
    int s0;
    s0 = swaps_seen;
    wq.delete();
    set_pair(5, regs[5] ^ ($urandom | 32'h1));
    for (int i = 0; i < 60 && !(coef_we === 1'b1 && coef_addr == 4'd5); i++) tick();
    checks++;
    if (!(coef_we === 1'b1 && coef_addr == 4'd5)) begin
      failures++;
      $display("FAIL sw_reach5 got=%h exp=5", coef_addr);
    end
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    for (int i = 0; i < 60 && !(coef_we === 1'b1 && coef_addr == 4'd15); i++) tick();
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    repeat (4) tick();
    checks++;
    if (swaps_seen != s0 || busy !== 1'b1 || coef_we !== 1'b0) begin
      failures++;
      $display("FAIL sw_no_swap got=%0d busy=%b exp=0 busy=1", swaps_seen - s0, busy);
    end
    checks++;
    if (wq.size() != NT) begin
      failures++;
      $display("FAIL sw_count got=%0d exp=%0d", wq.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wq[i] !== {4'(i), exp_tap(i)}) begin
          failures++;
          $display("FAIL sw_tap%0d got=%h exp=%h", i, wq[i], {4'(i), exp_tap(i)});
        end
      end
    end
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checks++;
    if (coef_swap !== 1'b1) begin
      failures++;
      $display("FAIL sw_swap got=%b exp=1", coef_swap);
    end
    exp_swaps++; exp_cnt++;
    tick();
  endtask

  task automatic test_change_in_arm();
    wq.delete();
    set_pair(2, regs[2] ^ ($urandom | 32'h1));
    for (int i = 0; i < 60 && wq.size() < NT; i++) tick();
    tick(); tick();
    wq.delete();
    set_pair(1, 32'h12345678);
    tick(); tick();
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checks++;
    if (coef_swap !== 1'b1) begin
      failures++;
      $display("FAIL arm_first_swap got=%b exp=1", coef_swap);
    end
    exp_swaps++; exp_cnt++;
    for (int i = 0; i < 80 && wq.size() < NT; i++) tick();
    tick(); tick();
    checks++;
    if (wq.size() != NT) begin
      failures++;
      $display("FAIL arm_count got=%0d exp=%0d", wq.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wq[i] !== {4'(i), exp_tap(i)}) begin
          failures++;
          $display("FAIL arm_tap%0d got=%h exp=%h", i, wq[i], {4'(i), exp_tap(i)});
        end
      end
    end
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checks++;
    if (coef_swap !== 1'b1) begin
      failures++;
      $display("FAIL arm_second_swap got=%b exp=1", coef_swap);
    end
    exp_swaps++; exp_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_write();
    int s0;
    wq.delete();
    set_pair(6, regs[6] ^ ($urandom | 32'h1));
    for (int i = 0; i < 60 && !(coef_we === 1'b1 && coef_addr == 4'd7); i++) tick();
    s0 = swaps_seen;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({coef_we, coef_swap, busy, coef_addr, coef_data} !== 23'h0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0", {coef_we, coef_swap, busy, coef_addr, coef_data});
    end
    exp_cnt = '0;
    sync_in = 1'b1; tick(); sync_in = 1'b0; tick();
    wq.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 80 && wq.size() < NT; i++) tick();
    repeat (3) tick();
    checks++;
    if (swaps_seen != s0) begin
      failures++;
      $display("FAIL rst_no_swap got=%0d exp=0", swaps_seen - s0);
    end
    checks++;
    if (wq.size() != NT) begin
      failures++;
      $display("FAIL rst_count got=%0d exp=%0d", wq.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wq[i] !== {4'(i), exp_tap(i)}) begin
          failures++;
          $display("FAIL rst_tap%0d got=%h exp=%h", i, wq[i], {4'(i), exp_tap(i)});
        end
      end
    end
    sync_in = 1'b1; tick(); sync_in = 1'b0;
    checks++;
    if (coef_swap !== 1'b1) begin
      failures++;
      $display("FAIL rst_swap got=%b exp=1", coef_swap);
    end
    exp_swaps++; exp_cnt++;
    tick();
  endtask

  task automatic test_random();
    int p;
    logic [31:0] old;
    wq.delete();
    p = $urandom_range(0, NP-1);
    old = regs[p];
    set_pair(p, old ^ ($urandom | 32'h1));
    repeat (SC-1) tick();
    set_pair(p, old);
    repeat (3*SC+10) tick();
    checks++;
    if (wq.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL revert got=%0d busy=%b exp=0 busy=0", wq.size(), busy);
    end
    for (int it = 0; it < 4; it++) begin
      wq.delete();
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        p = $urandom_range(0, NP-1);
        set_pair(p, regs[p] ^ ($urandom | 32'h1));
      end
      for (int i = 0; i < 80 && wq.size() < NT; i++) tick();
      tick(); tick();
      checks++;
      if (wq.size() != NT) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d exp=%0d", it, wq.size(), NT);
      end else begin
        for (int i = 0; i < NT; i++) begin
          checks++;
          if (wq[i] !== {4'(i), exp_tap(i)}) begin
            failures++;
            $display("FAIL rand%0d_tap%0d got=%h exp=%h", it, i, wq[i], {4'(i), exp_tap(i)});
          end
        end
      end
      sync_in = 1'b1; tick(); sync_in = 1'b0;
      checks++;
      if (coef_swap !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_swap got=%b exp=1", it, coef_swap);
      end
      exp_swaps++; exp_cnt++;
      tick();
    end
  endtask

  task automatic test_swap_cnt();
    tick(); tick();
    checks++;
    if (swaps_seen != exp_swaps) begin
      failures++;
      $display("FAIL swap_total got=%0d exp=%0d", swaps_seen, exp_swaps);
    end
    checks++;
`ifdef FIR_COEF_CNT_EN
    if (swap_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL swap_cnt got=%0d exp=%0d", swap_cnt, exp_cnt);
    end
`else
    if (swap_cnt !== 16'h0) begin
      failures++;
      $display("FAIL swap_cnt got=%0d exp=0 (swaps=%0d)", swap_cnt, exp_cnt);
    end
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_sync_during_write();
    test_change_in_arm();
    test_reset_mid_write();
    test_random();
    test_swap_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
